// File: rtl/sorted_array_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sorted_array_loader
//
// Feeder for the duplicate-removal stage. Elements arrive over a valid/ready
// handshake and are packed into an array of up to NUM_ELEMENTS entries. The
// stream is checked to be non-decreasing (signed compare). A closed batch
// (array plus element count) is held for the consumer until it acknowledges.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in_valid     producer has an element on in_data
//   in_data      element value, two's-complement signed
//   in_last      in_data is the final element of the batch
//   in_ready     loader accepts an element this cycle (registered)
//   nums         batch contents, [0:NUM_ELEMENTS-1], unused entries read 0
//   len          number of valid entries in nums
//   batch_valid  nums/len hold a complete batch (registered)
//   batch_ack    consumer has taken the batch
//   sort_err     batch contained a strictly decreasing adjacent pair
// -----------------------------------------------------------------------------
module sorted_array_loader #(
    parameter int NUM_ELEMENTS = 10,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] nums [0:NUM_ELEMENTS-1],
    output logic [31:0]           len,
    output logic                  batch_valid,
    input  logic                  batch_ack,
    output logic                  sort_err
);

    localparam int PTR_W = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
    localparam logic [PTR_W-1:0] MAX_PTR = PTR_W'(NUM_ELEMENTS - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_inReady;
    logic                  r_batchValid;
    logic                  r_sortErr;
    logic [31:0]           r_len;
    logic [PTR_W-1:0]      r_wrPtr;
    logic [DATA_WIDTH-1:0] r_prev;
    logic [DATA_WIDTH-1:0] r_nums [0:NUM_ELEMENTS-1];

    logic w_xfer;
    logic w_close;
    logic w_descending;

    // A transfer only happens in FILL, since in_ready is low throughout HOLD.
    assign w_xfer       = in_valid && r_inReady;
    // The batch closes on an explicit last or when the final slot is written.
    assign w_close      = in_last || (r_wrPtr == MAX_PTR);
    // The first element of a batch has no predecessor, so it is never compared.
    assign w_descending = (r_wrPtr != '0) && ($signed(in_data) < $signed(r_prev));

    // Single state machine holding the array, counters and registered
    // handshake outputs. in_ready/batch_valid change together with the state
    // so neither has a combinational path from in_valid or batch_ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= FILL;
            r_inReady    <= 1'b1;
            r_batchValid <= 1'b0;
            r_sortErr    <= 1'b0;
            r_len        <= '0;
            r_wrPtr      <= '0;
            r_prev       <= '0;
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                r_nums[i] <= '0;
            end
        end else begin
            case (r_state)
                FILL: begin
                    if (w_xfer) begin
                        r_nums[r_wrPtr] <= in_data;
                        r_prev          <= in_data;
                        r_len           <= r_len + 32'd1;
                        if (w_descending) begin
                            r_sortErr <= 1'b1;
                        end
                        if (w_close) begin
                            // Pointer stays on the last written slot; it is
                            // reset on acknowledge so it never runs past the end.
                            r_state      <= HOLD;
                            r_inReady    <= 1'b0;
                            r_batchValid <= 1'b1;
                        end else begin
                            r_wrPtr <= r_wrPtr + PTR_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (batch_ack) begin
                        r_state      <= FILL;
                        r_inReady    <= 1'b1;
                        r_batchValid <= 1'b0;
                        r_sortErr    <= 1'b0;
                        r_len        <= '0;
                        r_wrPtr      <= '0;
                        for (int i = 0; i < NUM_ELEMENTS; i++) begin
                            r_nums[i] <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    assign in_ready    = r_inReady;
    assign batch_valid = r_batchValid;
    assign sort_err    = r_sortErr;
    assign len         = r_len;
    assign nums        = r_nums;

endmodule

// File: tb/tb_sorted_array_loader.sv
`timescale 1ns/1ps
// Directed bench for sorted_array_loader with hand-computed expectations.
module tb_sorted_array_loader;

    localparam int N = 10;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic [31:0] inData;
    logic        inLast;
    logic        inReady;
    logic [31:0] nums [0:N-1];
    logic [31:0] len;
    logic        batchValid;
    logic        batchAck;
    logic        sortErr;

    int checks;
    int errors;
    logic [31:0] expNums [0:N-1];

    sorted_array_loader #(.NUM_ELEMENTS(N), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (inValid),
        .in_data    (inData),
        .in_last    (inLast),
        .in_ready   (inReady),
        .nums       (nums),
        .len        (len),
        .batch_valid(batchValid),
        .batch_ack  (batchAck),
        .sort_err   (sortErr)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs on the falling edge, let one rising edge pass, then settle
    // 1 ns so checks sample away from the active edge.
    task automatic applyStimulus(input logic v, input logic [31:0] d,
                                 input logic l, input logic a);
        @(negedge clk);
        inValid  = v;
        inData   = d;
        inLast   = l;
        batchAck = a;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkNums(input string tag);
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("%s_nums%0d", tag, i), nums[i], expNums[i]);
        end
    endtask

    task automatic clearExp();
        for (int i = 0; i < N; i++) expNums[i] = 32'd0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        inValid  = 1'b0;
        inData   = 32'd0;
        inLast   = 1'b0;
        batchAck = 1'b0;
        clearExp();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(inReady), 32'd1);
        checkOutput("rst_bv", 32'(batchValid), 32'd0);
        checkOutput("rst_len", len, 32'd0);
        checkOutput("rst_err", 32'(sortErr), 32'd0);
        checkNums("rst");

        // Sorted batch 0,0,1,1,1,2,2,3 with last on 3
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 2, 0, 0);
        applyStimulus(1, 2, 0, 0);
        checkOutput("s1_bv_before_last", 32'(batchValid), 32'd0);
        applyStimulus(1, 3, 1, 0);
        checkOutput("s1_bv", 32'(batchValid), 32'd1);
        checkOutput("s1_len", len, 32'd8);
        checkOutput("s1_err", 32'(sortErr), 32'd0);
        checkOutput("s1_ready", 32'(inReady), 32'd0);
        expNums[0] = 0; expNums[1] = 0; expNums[2] = 1; expNums[3] = 1;
        expNums[4] = 1; expNums[5] = 2; expNums[6] = 2; expNums[7] = 3;
        checkNums("s1");
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("s1_hold_bv", 32'(batchValid), 32'd1);
        checkOutput("s1_hold_ready", 32'(inReady), 32'd0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("s1_ack_bv", 32'(batchValid), 32'd0);
        checkOutput("s1_ack_len", len, 32'd0);
        checkOutput("s1_ack_ready", 32'(inReady), 32'd1);
        clearExp();
        checkNums("s1_ack");

        // Unsorted batch 5,3,7
        applyStimulus(1, 5, 0, 0);
        applyStimulus(1, 3, 0, 0);
        applyStimulus(1, 7, 1, 0);
        checkOutput("s2_len", len, 32'd3);
        checkOutput("s2_err", 32'(sortErr), 32'd1);
        checkOutput("s2_bv", 32'(batchValid), 32'd1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("s2_err_sticky", 32'(sortErr), 32'd1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("s2_ack_err", 32'(sortErr), 32'd0);
        checkOutput("s2_ack_len", len, 32'd0);
        checkOutput("s2_ack_ready", 32'(inReady), 32'd1);

        // Capacity close: -1..8, no last
        for (int v = -1; v <= 8; v++) begin
            applyStimulus(1, 32'(v), 0, 0);
        end
        checkOutput("s3_bv", 32'(batchValid), 32'd1);
        checkOutput("s3_len", len, 32'd10);
        checkOutput("s3_err", 32'(sortErr), 32'd0);
        for (int i = 0; i < N; i++) expNums[i] = 32'(i - 1);
        checkNums("s3");

        // Backpressure: 9 held valid during HOLD
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 9, 1, 0);
        end
        checkOutput("s4_len", len, 32'd10);
        checkOutput("s4_bv", 32'(batchValid), 32'd1);
        checkNums("s4_hold");
        applyStimulus(1, 9, 1, 1);
        checkOutput("s4_ack_ready", 32'(inReady), 32'd1);
        checkOutput("s4_ack_len", len, 32'd0);
        applyStimulus(1, 9, 1, 0);
        checkOutput("s4_new_bv", 32'(batchValid), 32'd1);
        checkOutput("s4_new_len", len, 32'd1);
        checkOutput("s4_new_nums0", nums[0], 32'd9);
        checkOutput("s4_new_nums1", nums[1], 32'd0);
        applyStimulus(0, 0, 0, 1);

        // Gaps in in_valid, then single element
        applyStimulus(1, 10, 0, 0);
        applyStimulus(0, 99, 0, 0);
        applyStimulus(1, 20, 0, 0);
        applyStimulus(0, 5, 0, 0);
        applyStimulus(0, 5, 1, 0);
        applyStimulus(1, 20, 0, 0);
        applyStimulus(1, 30, 1, 0);
        checkOutput("s5_len", len, 32'd4);
        checkOutput("s5_err", 32'(sortErr), 32'd0);
        clearExp();
        expNums[0] = 10; expNums[1] = 20; expNums[2] = 20; expNums[3] = 30;
        checkNums("s5");
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 42, 1, 0);
        checkOutput("s5_single_len", len, 32'd1);
        checkOutput("s5_single_nums0", nums[0], 32'd42);
        checkOutput("s5_single_err", 32'(sortErr), 32'd0);
        checkOutput("s5_single_bv", 32'(batchValid), 32'd1);
        applyStimulus(0, 0, 0, 1);

        // Async reset mid-batch
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 2, 0, 0);
        applyStimulus(1, 3, 0, 0);
        checkOutput("s6_pre_len", len, 32'd3);
        inValid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("s6_rst_len", len, 32'd0);
        checkOutput("s6_rst_bv", 32'(batchValid), 32'd0);
        checkOutput("s6_rst_ready", 32'(inReady), 32'd1);
        clearExp();
        checkNums("s6_rst");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 32'hFFFF_FFFE, 0, 0);
        applyStimulus(1, 7, 1, 0);
        checkOutput("s6_new_len", len, 32'd2);
        checkOutput("s6_new_nums0", nums[0], 32'hFFFF_FFFE);
        checkOutput("s6_new_nums1", nums[1], 32'd7);
        checkOutput("s6_new_err", 32'(sortErr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
